// File: rtl/ps2_kbd_pkg.sv
// Shared constants, frame-state encoding and code-conversion helpers for the
// PS/2 keyboard receiver.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

  // Scan-code set 2 to ASCII; letters derive their upper case from the lower.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'h00;
    hi = 8'h00;
    case (code)
      8'h1C: lo = 8'h61;  8'h32: lo = 8'h62;  8'h21: lo = 8'h63;  8'h23: lo = 8'h64;
      8'h24: lo = 8'h65;  8'h2B: lo = 8'h66;  8'h34: lo = 8'h67;  8'h33: lo = 8'h68;
      8'h43: lo = 8'h69;  8'h3B: lo = 8'h6A;  8'h42: lo = 8'h6B;  8'h4B: lo = 8'h6C;
      8'h3A: lo = 8'h6D;  8'h31: lo = 8'h6E;  8'h44: lo = 8'h6F;  8'h4D: lo = 8'h70;
      8'h15: lo = 8'h71;  8'h2D: lo = 8'h72;  8'h1B: lo = 8'h73;  8'h2C: lo = 8'h74;
      8'h3C: lo = 8'h75;  8'h2A: lo = 8'h76;  8'h1D: lo = 8'h77;  8'h22: lo = 8'h78;
      8'h35: lo = 8'h79;  8'h1A: lo = 8'h7A;
      8'h45: begin lo = 8'h30; hi = 8'h29; end
      8'h16: begin lo = 8'h31; hi = 8'h21; end
      8'h1E: begin lo = 8'h32; hi = 8'h40; end
      8'h26: begin lo = 8'h33; hi = 8'h23; end
      8'h25: begin lo = 8'h34; hi = 8'h24; end
      8'h2E: begin lo = 8'h35; hi = 8'h25; end
      8'h36: begin lo = 8'h36; hi = 8'h5E; end
      8'h3D: begin lo = 8'h37; hi = 8'h26; end
      8'h3E: begin lo = 8'h38; hi = 8'h2A; end
      8'h46: begin lo = 8'h39; hi = 8'h28; end
      8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
      8'h55: begin lo = 8'h3D; hi = 8'h2B; end
      8'h54: begin lo = 8'h5B; hi = 8'h7B; end
      8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
      8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = 8'h2C; hi = 8'h3C; end
      8'h49: begin lo = 8'h2E; hi = 8'h3E; end
      8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
      8'h29: begin lo = 8'h20; hi = 8'h20; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      default: begin lo = 8'h00; hi = 8'h00; end
    endcase
    hi = (lo >= 8'h61 && lo <= 8'h7A) ? (lo - 8'h20) : hi;
    return shift ? hi : lo;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_frame.sv
// PS/2 device-to-host framer: pin synchronisation, falling-edge detect,
// 11-bit frame shifter with odd-parity/stop check and an inter-edge timeout.
import ps2_kbd_pkg::*;

module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic         clk_meta_r, clk_sync_r, clk_old_r;
  logic         data_meta_r, data_sync_r;
  logic         fall_s, timeout_s, frame_ok_s;
  frame_state_e state_r, state_s;
  logic [3:0]   bit_cnt_r;
  logic [7:0]   shift_r;
  logic         parity_r;
  logic [TW-1:0] to_cnt_r;

  assign fall_s     = clk_old_r & ~clk_sync_r;
  assign timeout_s  = (state_r != IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok_s = data_sync_r && odd_parity_ok(shift_r, parity_r);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a timeout abandons the frame from any non-idle state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s && !data_sync_r) state_s = DATA;
        else                        state_s = IDLE;
      end
      DATA: begin
        if (timeout_s)                          state_s = IDLE;
        else if (fall_s && bit_cnt_r == 4'd7)   state_s = PARITY;
        else                                    state_s = DATA;
      end
      PARITY: begin
        if (timeout_s)   state_s = IDLE;
        else if (fall_s) state_s = STOP;
        else             state_s = PARITY;
      end
      STOP: begin
        if (timeout_s)   state_s = IDLE;
        else if (fall_s) state_s = IDLE;
        else             state_s = STOP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode: the stop-bit edge either releases the byte or flags an error.
  always_comb begin
    byte_valid  = 1'b0;
    frame_error = timeout_s;
    case (state_r)
      STOP: begin
        if (fall_s) begin
          byte_valid  = frame_ok_s;
          frame_error = !frame_ok_s;
        end else begin
          byte_valid  = 1'b0;
          frame_error = timeout_s;
        end
      end
      default: begin
        byte_valid  = 1'b0;
        frame_error = timeout_s;
      end
    endcase
  end

  assign byte_data = shift_r;

  // Synchronisers, bit shifter, bit counter and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_old_r   <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'h00;
      parity_r    <= 1'b0;
      to_cnt_r    <= '0;
    end else begin
      clk_meta_r  <= ps2_clk_async;
      clk_sync_r  <= clk_meta_r;
      clk_old_r   <= clk_sync_r;
      data_meta_r <= ps2_data_async;
      data_sync_r <= data_meta_r;
      if (fall_s) begin
        case (state_r)
          IDLE:    bit_cnt_r <= 4'd0;
          DATA: begin
            shift_r   <= {data_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
          PARITY: begin
            parity_r  <= data_sync_r;
            bit_cnt_r <= 4'd9;
          end
          STOP:    bit_cnt_r <= 4'd10;
          default: bit_cnt_r <= 4'd0;
        endcase
      end
      if (state_r == IDLE || fall_s || timeout_s) to_cnt_r <= '0;
      else                                        to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: scan-code set 2 make/break/extended decoder
// with shift tracking, feeding the keyboard register and interrupt logic.
import ps2_kbd_pkg::*;

module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic       key_pressed,
  output logic       key_released,
  output logic       frame_error
);

  logic       rx_valid_s, rx_error_s, is_mod_s;
  logic [7:0] rx_byte_s;
  logic [7:0] scan_code_r, ascii_code_r;
  logic       key_pressed_r, key_released_r, frame_error_r;
  logic       brk_r, ext_r, lshift_r, rshift_r;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
    .clk            (clk),
    .reset          (reset),
    .ps2_clk_async  (ps2_clk_async),
    .ps2_data_async (ps2_data_async),
    .byte_valid     (rx_valid_s),
    .byte_data      (rx_byte_s),
    .frame_error    (rx_error_s)
  );

  // Extended shift codes are distinct keys, so only plain 0x12/0x59 are modifiers.
  assign is_mod_s = !ext_r && (rx_byte_s == PS2_LSHIFT || rx_byte_s == PS2_RSHIFT);

  // Sequence decoder and registered key outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_code_r    <= 8'h00;
      ascii_code_r   <= 8'h00;
      key_pressed_r  <= 1'b0;
      key_released_r <= 1'b0;
      frame_error_r  <= 1'b0;
      brk_r          <= 1'b0;
      ext_r          <= 1'b0;
      lshift_r       <= 1'b0;
      rshift_r       <= 1'b0;
    end else begin
      key_released_r <= 1'b0;
      frame_error_r  <= rx_error_s;
      if (rx_valid_s) begin
        case (rx_byte_s)
          PS2_EXT:   ext_r <= 1'b1;
          PS2_BREAK: brk_r <= 1'b1;
          default: begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
            if (brk_r) key_released_r <= 1'b1;
            if (is_mod_s) begin
              if (rx_byte_s == PS2_LSHIFT) lshift_r <= !brk_r;
              else                         rshift_r <= !brk_r;
            end else if (brk_r) begin
              if (rx_byte_s == scan_code_r) key_pressed_r <= 1'b0;
            end else begin
              scan_code_r   <= rx_byte_s;
              key_pressed_r <= 1'b1;
              ascii_code_r  <= ext_r ? 8'h00 : scan_to_ascii(rx_byte_s, lshift_r | rshift_r);
            end
          end
        endcase
      end
    end
  end

  assign scan_code    = scan_code_r;
  assign ascii_code   = ascii_code_r;
  assign key_pressed  = key_pressed_r;
  assign key_released = key_released_r;
  assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: stimulus queues expected output events,
// a negedge monitor pops and compares whenever the outputs change or pulse.
`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

  localparam logic [1:0] K_UPD = 2'd0;
  localparam logic [1:0] K_REL = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] scan;
    logic [7:0] ascii;
    logic       pressed;
    string      name;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_async = 1'b1;
  logic       ps2_data_async = 1'b1;
  logic [7:0] scan_code, ascii_code;
  logic       key_pressed, key_released, frame_error;

  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  logic [7:0] prev_scan, prev_ascii;
  logic       prev_pressed, prev_rel, prev_err;
  logic [1:0] obs_kind;
  ev_t        cur_e;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(1000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_clk_async  (ps2_clk_async),
    .ps2_data_async (ps2_data_async),
    .scan_code      (scan_code),
    .ascii_code     (ascii_code),
    .key_pressed    (key_pressed),
    .key_released   (key_released),
    .frame_error    (frame_error)
  );

  always #10 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d required 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic expect_ev(input logic [1:0] k, input logic [7:0] s, input logic [7:0] a,
                           input logic p, input string n);
    ev_t e;
    e.kind = k; e.scan = s; e.ascii = a; e.pressed = p; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string n, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, req);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data_async = b;
    repeat (5) @(posedge clk);
    ps2_clk_async = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk_async = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop);
    ps2_data_async = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic check_zero_outputs(input string n);
    @(negedge clk);
    check_val({n, "_scan"}, scan_code, 8'h00);
    check_val({n, "_ascii"}, ascii_code, 8'h00);
    check_val({n, "_pressed"}, {7'd0, key_pressed}, 8'h00);
    check_val({n, "_released"}, {7'd0, key_released}, 8'h00);
    check_val({n, "_ferr"}, {7'd0, frame_error}, 8'h00);
  endtask

  // Monitor: every pulse or output change consumes one expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (key_released && prev_rel) begin
        checks++; errors++;
        $display("FAIL released_width: high for 2 cycles, required 1");
      end
      if (frame_error && prev_err) begin
        checks++; errors++;
        $display("FAIL ferr_width: high for 2 cycles, required 1");
      end
      if (frame_error || key_released || scan_code !== prev_scan ||
          ascii_code !== prev_ascii || key_pressed !== prev_pressed) begin
        obs_kind = frame_error ? K_ERR : (key_released ? K_REL : K_UPD);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind=%0d scan=%h ascii=%h pressed=%b, required no event",
                   obs_kind, scan_code, ascii_code, key_pressed);
        end else begin
          cur_e = exp_q.pop_front();
          if (obs_kind !== cur_e.kind || scan_code !== cur_e.scan ||
              ascii_code !== cur_e.ascii || key_pressed !== cur_e.pressed) begin
            errors++;
            $display("FAIL %s: kind=%0d scan=%h ascii=%h pressed=%b, required kind=%0d scan=%h ascii=%h pressed=%b",
                     cur_e.name, obs_kind, scan_code, ascii_code, key_pressed,
                     cur_e.kind, cur_e.scan, cur_e.ascii, cur_e.pressed);
          end
        end
      end
      prev_scan    = scan_code;
      prev_ascii   = ascii_code;
      prev_pressed = key_pressed;
      prev_rel     = key_released;
      prev_err     = frame_error;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    reset = 1'b0;
    check_zero_outputs("reset");
    prev_scan = 8'h00; prev_ascii = 8'h00; prev_pressed = 1'b0;
    prev_rel = 1'b0; prev_err = 1'b0;
    mon_en = 1'b1;

    expect_ev(K_UPD, 8'h1C, 8'h61, 1'b1, "make_a");
    send(8'h1C);

    send(8'h12);
    expect_ev(K_UPD, 8'h1C, 8'h41, 1'b1, "shift_make_A");
    send(8'h1C);
    expect_ev(K_REL, 8'h1C, 8'h41, 1'b1, "shift_release");
    send(8'hF0); send(8'h12);
    expect_ev(K_UPD, 8'h16, 8'h31, 1'b1, "make_1_unshifted");
    send(8'h16);

    expect_ev(K_UPD, 8'h1C, 8'h61, 1'b1, "make_a_again");
    send(8'h1C);
    expect_ev(K_REL, 8'h1C, 8'h61, 1'b1, "break_other_key");
    send(8'hF0); send(8'h32);
    expect_ev(K_REL, 8'h1C, 8'h61, 1'b0, "break_held_key");
    send(8'hF0); send(8'h1C);

    expect_ev(K_ERR, 8'h1C, 8'h61, 1'b0, "parity_error");
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_ev(K_UPD, 8'h1B, 8'h73, 1'b1, "make_s_after_perr");
    send(8'h1B);

    expect_ev(K_ERR, 8'h1B, 8'h73, 1'b1, "stop_error");
    send_frame(8'h1C, 1'b0, 1'b0);

    expect_ev(K_ERR, 8'h1B, 8'h73, 1'b1, "timeout");
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data_async = 1'b1;
    repeat (1100) @(posedge clk);
    expect_ev(K_UPD, 8'h29, 8'h20, 1'b1, "space_after_timeout");
    send(8'h29);

    expect_ev(K_UPD, 8'h75, 8'h00, 1'b1, "extended_make");
    send(8'hE0); send(8'h75);

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data_async = 1'b1;
    expect_ev(K_UPD, 8'h00, 8'h00, 1'b0, "reset_midframe");
    @(posedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    reset = 1'b0;
    check_zero_outputs("post_reset");
    expect_ev(K_UPD, 8'h1C, 8'h61, 1'b1, "make_after_reset");
    send(8'h1C);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver for the on-board CPU system. It takes the asynchronous PS/2 clock and data lines and frames 11-bit device-to-host packets. It decodes scan-code set 2 make/break/extended sequences and presents the last key as a scan code plus ASCII, with press/release indications. Its outputs feed the bus keyboard register and the interrupt controller; all logic runs in the 50 MHz system domain.

## Interface
- `TIMEOUT_CYCLES`, default 50_000: system clocks without a PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz).
- `clk`  in  1: system clock, 50 MHz.
- `reset`  in  1: synchronous, active-high reset.
- `ps2_clk_async`  in  1: raw PS/2 clock from the pin.
- `ps2_data_async`  in  1: raw PS/2 data from the pin.
- `scan_code`  out  8: last make code of a non-modifier key; the 0xE0 prefix is not included.
- `ascii_code`  out  8: ASCII of `scan_code` under the current shift state; 0x00 if unmapped or extended.
- `key_pressed`  out  1: level; high while the key in `scan_code` is held.
- `key_released`  out  1: one-cycle pulse on every completed break sequence.
- `frame_error`  out  1: one-cycle pulse on a parity error, a stop-bit error or a timeout.

## Operation
- **Synchronisation:** both inputs pass through 2-flop synchronizers. A falling edge is the synchronized clock going 1→0 (old value held in a third flop).
- **Frame format:** start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1.
  - Bits are sampled on the cycle the falling edge is detected.
  - A start bit of 1 is ignored; the receiver stays idle.
- **Bit counter:** counts 0..10. The frame completes at count 10.
  - Valid frame: byte released to the decoder.
  - Parity or stop error: `frame_error` pulses and the byte is dropped.
- **Timeout:** a counter runs while mid-frame and restarts on each falling edge. Reaching `TIMEOUT_CYCLES` discards the frame, pulses `frame_error` and returns to idle.
- **Decoder flags:** `brk` and `ext`.
  - 0xE0 sets `ext`. 0xF0 sets `brk`.
  - Any other byte completes a sequence and clears both flags afterwards.
- **Modifiers:** left shift 0x12 and right shift 0x59, when not extended, only set or clear their shift bit. They never touch `scan_code` or `key_pressed`.
- **Make** (`brk`=0):
  - `scan_code` ← byte and `key_pressed` ← 1.
  - `ascii_code` ← table lookup, or 0x00 when `ext`=1 or the code is unmapped.
  - A typematic repeat of the same code rewrites the same values.
- **Break** (`brk`=1):
  - `key_released` pulses.
  - `key_pressed` ← 0 only if the byte equals `scan_code`.
  - `scan_code` and `ascii_code` are held.
- **ASCII table**, with the shifted result after the slash:
  - Letters 'a'–'z' / 'A'–'Z'.
  - Digits '0'–'9' / `)!@#$%^&*(`.
  - Space 0x29 → 0x20, Enter 0x5A → 0x0D, Backspace 0x66 → 0x08.
  - Punctuation `-=[];',./` / `_+{}:"<>?`.
- **Reset:**
  - Outputs: all zero.
  - Internal state: synchronizer flops to 1, flags and shift state to 0, frame state to idle.
  - Reset mid-frame aborts the frame without a `frame_error` pulse.

## Timing
- Pin to detected falling edge: 3 `clk` cycles.
- `scan_code`, `ascii_code`, `key_pressed` and `key_released` all update in the cycle after the stop bit is sampled.
- `frame_error` has the same latency for parity and stop errors; for a timeout it asserts in the cycle the counter hits the limit.
- Pulses are exactly one cycle wide. Consumers edge-detect `key_pressed` for per-press events.
- A new frame may start on the first falling edge after completion; no idle gap is required.

## Structure
- **Package `ps2_kbd_pkg`:**
  - Constants `PS2_BREAK`=0xF0, `PS2_EXT`=0xE0, `PS2_LSHIFT`=0x12, `PS2_RSHIFT`=0x59.
  - Frame-state enum {IDLE, DATA, PARITY, STOP}.
  - Pure function `scan_to_ascii(code, shift)`.
- **Sub-module `ps2_frame_rx`:** synchronizer, edge detect, shifter, parity check and timeout. Outputs are a byte-valid pulse, the byte and an error pulse. The parent holds the decoder flags and output registers.

## Test plan
- **Make 'a':** send 0x1C with valid parity → after the stop bit, `scan_code`=0x1C, `ascii_code`=0x61, `key_pressed`=1.
- **Shifted make:** 0x12, then 0x1C → `ascii_code`=0x41. Then F0 12, then 0x16 → `ascii_code`=0x31.
- **Break:** with 0x1C held, send F0 1C → one-cycle `key_released`, `key_pressed`=0, `scan_code` stays 0x1C.
  - Also: F0 32 while 0x1C is held → pulse only, `key_pressed` stays 1.
- **Parity error:** send 0x1C with even parity → `frame_error` pulse, outputs unchanged. The next valid 0x1B is then decoded → `ascii_code`=0x73.
- **Timeout:** stop after 5 bits for more than `TIMEOUT_CYCLES` (use 1000 in the bench) → `frame_error` pulse. A following full frame of 0x29 → `ascii_code`=0x20.
- **Extended and reset:** E0 75 → `scan_code`=0x75, `ascii_code`=0x00. Assert `reset` midway through the next frame → all outputs 0 and no error pulse; the next frame decodes normally.
